excess3_to_bcd_serial: RTL and testbench

//   Decodes a multi-digit Excess-3 word back to packed BCD, one digit per clock, LSD first.

---
 rtl/excess3_to_bcd_serial_if.sv | 37 +++
 rtl/excess3_to_bcd_serial.sv | 88 ++++++++
 tb/tb_excess3_to_bcd_serial.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/excess3_to_bcd_serial_if.sv
// Handshake bundle for the serial Excess-3 to BCD decoder: word input side and result side.
interface excess3_to_bcd_serial_if #(
  parameter int unsigned NDIG = 4
);
  logic                in_valid;
  logic                in_ready;
  logic [4*NDIG-1:0]   in_xs3;
  logic                out_valid;
  logic                out_ready;
  logic [4*NDIG-1:0]   out_bcd;
  logic [NDIG-1:0]     out_err;
  logic                out_any_err;

  // Producer/consumer side (drives words in, takes results out)
  modport master (
    output in_valid,
    input  in_ready,
    output in_xs3,
    input  out_valid,
    output out_ready,
    input  out_bcd,
    input  out_err,
    input  out_any_err
  );

  // Decoder side
  modport slave (
    input  in_valid,
    output in_ready,
    input  in_xs3,
    output out_valid,
    input  out_ready,
    output out_bcd,
    output out_err,
    output out_any_err
  );
endinterface

// File: rtl/excess3_to_bcd_serial.sv
// Decodes an NDIG-digit Excess-3 word to packed BCD one digit per clock, LSD first,
// flagging illegal codes per digit. Valid/ready on both sides; no overlap of accept and output.
module excess3_to_bcd_serial #(
  parameter int unsigned NDIG = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  excess3_to_bcd_serial_if.slave        bus
);

  localparam int unsigned IdxW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NDIG - 1);

  typedef enum logic [1:0] {StIdle, StConv, StDone} state_e;

  state_e                 state_q, state_d;
  logic [IdxW-1:0]        idx_q, idx_d;
  logic [NDIG-1:0][3:0]   word_q, word_d;
  logic [NDIG-1:0][3:0]   bcd_q, bcd_d;
  logic [NDIG-1:0]        err_q, err_d;
  logic [3:0]             digit;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    word_d  = word_q;
    bcd_d   = bcd_q;
    err_d   = err_q;
    digit   = word_q[idx_q];

    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          word_d  = bus.in_xs3;
          bcd_d   = '0;
          err_d   = '0;
          idx_d   = '0;
          state_d = StConv;
        end
      end
      StConv: begin
        // Legal Excess-3 codes are 3..12; anything else decodes to 0 with its error bit set
        if ((digit >= 4'd3) && (digit <= 4'd12)) begin
          bcd_d[idx_q] = digit - 4'd3;
          err_d[idx_q] = 1'b0;
        end else begin
          bcd_d[idx_q] = 4'h0;
          err_d[idx_q] = 1'b1;
        end
        if (idx_q == LastIdx) begin
          state_d = StDone;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StDone: begin
        if (bus.out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      word_q  <= '0;
      bcd_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      bcd_q   <= bcd_d;
      err_q   <= err_d;
    end
  end

  // in_ready is held low while reset is asserted, even if the state register still reads idle
  assign bus.in_ready    = (state_q == StIdle) && !rst;
  assign bus.out_valid   = (state_q == StDone);
  assign bus.out_bcd     = bcd_q;
  assign bus.out_err     = err_q;
  assign bus.out_any_err = |err_q;

endmodule

// File: tb/tb_excess3_to_bcd_serial.sv
// Self-checking bench for excess3_to_bcd_serial (NDIG=4): directed cases plus random words
// compared against an arithmetic per-digit reference.
module tb_excess3_to_bcd_serial;

  localparam int unsigned NDIG = 4;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  excess3_to_bcd_serial_if #(.NDIG(NDIG)) bus ();

  excess3_to_bcd_serial #(.NDIG(NDIG)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: each nibble d decodes to d-3 when 3<=d<=12, else 0 with its error bit set
  task automatic model(input logic [15:0] x, output logic [15:0] b, output logic [3:0] e);
    int d;
    b = '0;
    e = '0;
    for (int i = 0; i < int'(NDIG); i++) begin
      d = (int'(x) >> (4 * i)) % 16;
      if (d >= 3 && d <= 12) b = b | 16'((d - 3) << (4 * i));
      else                   e = e | 4'(1 << i);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Send one word, check latency and results, stall 'stall' cycles in DONE, then hand off.
  task automatic run_word(input logic [15:0] x, input int stall);
    logic [15:0] eb;
    logic [3:0]  ee;
    int          n;
    int          lat;
    model(x, eb, ee);
    n = 0;
    while (!bus.in_ready && n < 20) begin
      tick();
      n++;
    end
    check("in_ready_idle", 32'(bus.in_ready), 32'd1);
    bus.in_valid  = 1'b1;
    bus.in_xs3    = x;
    bus.out_ready = 1'b0;
    tick();
    bus.in_valid = 1'b0;
    bus.in_xs3   = 16'($urandom);
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check("latency", 32'(lat), 32'(NDIG));
    check("out_bcd", 32'(bus.out_bcd), 32'(eb));
    check("out_err", 32'(bus.out_err), 32'(ee));
    check("out_any_err", 32'(bus.out_any_err), 32'(ee != 4'b0));
    for (int s = 0; s < stall; s++) begin
      bus.in_valid = 1'b1;
      bus.in_xs3   = 16'($urandom);
      tick();
      check("stall_valid", 32'(bus.out_valid), 32'd1);
      check("stall_in_ready", 32'(bus.in_ready), 32'd0);
      check("stall_bcd", 32'(bus.out_bcd), 32'(eb));
      check("stall_err", 32'(bus.out_err), 32'(ee));
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("valid_drop", 32'(bus.out_valid), 32'd0);
    check("in_ready_after", 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    logic [15:0] q[$];
    logic [15:0] w;
    logic [15:0] eb;
    logic [3:0]  ee;
    int          last_acc;
    int          nvalid;

    n_tests       = 0;
    n_fail        = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_xs3    = '0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_bcd", 32'(bus.out_bcd), 32'd0);
    check("rst_out_err", 32'(bus.out_err), 32'd0);
    check("rst_any_err", 32'(bus.out_any_err), 32'd0);
    rst = 1'b0;
    #1;

    // Directed examples, including a 10-cycle backpressure hold
    run_word(16'h4B6C, 0);
    run_word(16'h3F27, 10);

    // All 16 codes in digit 0
    for (int c = 0; c < 16; c++) begin
      w = {16'($urandom) & 16'hFFF0} | 16'(c);
      run_word(w, 0);
    end

    // Random words with random stalls
    for (int r = 0; r < 20; r++) begin
      run_word(16'($urandom), int'($urandom_range(0, 3)));
    end

    // Back-to-back: in_valid and out_ready held high
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    last_acc      = -1;
    for (int c = 0; c < 40; c++) begin
      bus.in_xs3 = 16'($urandom);
      #1;
      if (bus.in_ready) begin
        q.push_back(bus.in_xs3);
        if (last_acc >= 0) check("accept_interval", 32'(c - last_acc), 32'(NDIG + 2));
        last_acc = c;
      end
      if (bus.out_valid) begin
        if (q.size() == 0) begin
          check("b2b_unexpected_out", 32'd1, 32'd0);
        end else begin
          model(q.pop_front(), eb, ee);
          check("b2b_bcd", 32'(bus.out_bcd), 32'(eb));
          check("b2b_err", 32'(bus.out_err), 32'(ee));
        end
      end
      tick();
    end
    bus.in_valid = 1'b0;
    for (int c = 0; c < 10 && q.size() > 0; c++) begin
      if (bus.out_valid) begin
        model(q.pop_front(), eb, ee);
        check("drain_bcd", 32'(bus.out_bcd), 32'(eb));
        check("drain_err", 32'(bus.out_err), 32'(ee));
      end
      tick();
    end
    check("b2b_queue_empty", 32'(q.size()), 32'd0);
    bus.out_ready = 1'b0;
    tick();

    // Reset during the second CONV cycle discards the word
    bus.in_valid = 1'b1;
    bus.in_xs3   = 16'($urandom);
    tick();
    bus.in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_out_bcd", 32'(bus.out_bcd), 32'd0);
    check("midrst_out_err", 32'(bus.out_err), 32'd0);
    check("midrst_any_err", 32'(bus.out_any_err), 32'd0);
    check("midrst_in_ready", 32'(bus.in_ready), 32'd0);
    rst = 1'b0;
    #1;
    check("postrst_in_ready", 32'(bus.in_ready), 32'd1);
    nvalid = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (bus.out_valid) nvalid++;
    end
    check("postrst_no_valid", 32'(nvalid), 32'd0);
    run_word(16'h4B6C, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Hard bound in case the design never progresses
  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
